fpu_div_seq: RTL
================

Name: fpu_div_seq

Overview:
- Multi-cycle IEEE-754 single-precision divider for the FPU, z = a / b, sitting beside the combinational adder.
- Uses a radix-2 restoring mantissa divider.
- Rounding is round-to-nearest-even, using the same guard/round/sticky scheme as the adder.
- The divider shares the adder's canonical NaN encoding, 0xFFC00000.
- A valid/ready request and response handshake decouples it from the execute stage.

Parameters:
- QBITS, 26, quotient bits generated: 24 mantissa bits plus guard and round. Sticky comes from the final remainder.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_i  input  32  dividend.
- b_i  input  32  divisor.
- req_valid_i  input  1  operands valid.
- req_ready_o  output  1  unit can accept a request.
- z_o  output  32  quotient.
- resp_valid_o  output  1  z_o and flags_o are valid.
- resp_ready_i  input  1  consumer accepts the result.
- flags_o  output  5  {NV, DZ, OF, UF, NX}.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, req_ready_o=1, resp_valid_o=0, z_o=0, flags_o=0.
  - All datapath registers are cleared.
- States: IDLE -> UNPACK -> DIV -> ROUND -> DONE -> IDLE.
- IDLE:
  - req_ready_o=1.
  - Accept occurs when req_valid_i && req_ready_o at edge T.
  - Operands are latched and the unit goes to UNPACK.
  - req_ready_o=0 in every state other than IDLE.
- UNPACK (one cycle, T+1):
  - Special cases, which go straight to DONE:
    - Any NaN, 0/0, or inf/inf -> 0xFFC00000, NV.
    - x/0 with x finite nonzero -> inf with sign a^b, DZ.
    - inf/finite -> inf.
    - 0/nonzero, or finite/inf -> zero with sign a^b.
  - Otherwise:
    - Subnormal operands are normalised with a leading-zero count: exponent = 1 - lzc, mantissa shifted so bit 23 = 1.
    - Exponent is computed as ze = ea - eb + 127, 10-bit signed.
    - If ma < mb: dividend shifted left 1 and ze decremented, so the quotient lies in [1,2).
    - Iteration counter loaded with QBITS-1.
- DIV (QBITS cycles, T+2..T+27):
  - Each cycle: trial subtract rem - mb. If non-negative, take it and shift in quotient bit 1; else shift in 0.
  - rem <<= 1 after each step.
  - Exit when the counter reaches 0.
- ROUND (T+28):
  - If ze <= 0: right-shift the 26-bit quotient by 1 - ze, clamped to 26. Shifted-out bits OR into sticky; ze=0.
  - Sticky additionally includes (rem != 0).
  - RNE: increment when g && (r | s | lsb).
  - Mantissa carry-out increments the exponent; a subnormal that rounds up to 1.0 becomes exponent 1.
  - ze >= 255 after rounding -> inf, OF|NX.
  - Result registered into z_o and flags_o.
- DONE:
  - resp_valid_o=1; z_o and flags_o held stable while resp_ready_i=0.
  - On resp_valid_o && resp_ready_i: resp_valid_o=0 next edge, state goes to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency:
  - Normal path: resp_valid_o rises at T+29.
  - Special-case path: resp_valid_o rises at T+2.
  - Latency is independent of operand values within each path.
- Flags:
  - NX when g|r|s != 0.
  - UF when the result is tiny after rounding AND inexact.
  - OF as defined in ROUND.
- Reset mid-operation: immediate return to IDLE; no response is produced, and any partial result is discarded.

Optional Feature:
- Macro: FPU_DIV_FLAGS_EN.
- Defined: flags_o is computed as described above.
- Undefined:
  - flags_o is tied to 5'b0.
  - Flag logic and the remainder-nonzero detector feeding the flags are not synthesised.
  - Rounding still uses full sticky, so z_o is bit-identical in both builds.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> z_o=0x40400000, resp_valid_o at T+29, flags=0.
- 0x3F800000 / 0x40400000 (1/3) -> z_o=0x3EAAAAAB, flags=NX (0x01).
- 0x3F800000 / 0x00000000 -> 0x7F800000, DZ (0x08), resp_valid_o at T+2.
- 0x00000000 / 0x80000000 -> 0xFFC00000, NV (0x10), resp_valid_o at T+2.
- Subnormal cases:
  - 0x00000001 / 0x40000000 -> 0x00000000 (tie to even), UF|NX (0x03).
  - 0x3F800000 / 0x7F000000 -> 0x00400000, flags=0.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, OF|NX (0x05).
- Response backpressure: hold resp_ready_i=0 for 5 cycles.
  - z_o stable, resp_valid_o=1, req_ready_o=0 throughout.
- Reset mid-operation: assert rst low at T+10.
  - Outputs return to reset values immediately.
  - The next request completes normally.

Source files
------------

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 single-precision divider, radix-2 restoring, RNE.
// Define FPU_DIV_FLAGS_EN to build the exception flag logic.
module fpu_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic [31:0] z_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [4:0]  flags_o
);

  localparam int CW = $clog2(QBITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] DIV    = 3'd2;
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state;
  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] ze_q;
  logic [23:0]       mb_q;
  logic [25:0]       rem_q;
  logic [QBITS-1:0]  quo_q;
  logic [CW-1:0]     cnt_q;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) n = 5'(23 - i);
    return n;
  endfunction

  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic              a_zero, b_zero;
  logic              is_nv, is_dz, spec;
  logic [31:0]       spec_z;
  logic [4:0]        lza, lzb;
  logic [23:0]       ma, mb;
  logic signed [9:0] ea_n, eb_n, ze_n, ze_init;
  logic [25:0]       rem_init;
  logic              lt, sgn;

  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    fa = a_q[22:0];
    fb = b_q[22:0];
    sgn = a_q[31] ^ b_q[31];
    a_nan = (ea == 8'hFF) && (fa != '0);
    b_nan = (eb == 8'hFF) && (fb != '0);
    a_inf = (ea == 8'hFF) && (fa == '0);
    b_inf = (eb == 8'hFF) && (fb == '0);
    a_zero = (ea == 8'h00) && (fa == '0);
    b_zero = (eb == 8'h00) && (fb == '0);
    is_nv = a_nan | b_nan | (a_zero & b_zero)
          | (a_inf & b_inf);
    is_dz = !is_nv && b_zero && !a_inf;
    spec = is_nv | b_zero | a_inf | a_zero | b_inf;
    if (is_nv)
      spec_z = 32'hFFC0_0000;
    else if (b_zero || a_inf)
      spec_z = {sgn, 8'hFF, 23'd0};
    else
      spec_z = {sgn, 31'd0};
    // subnormals are normalised so bit 23 is always set
    lza = lzc24({1'b0, fa});
    lzb = lzc24({1'b0, fb});
    ma = (ea == '0) ? ({1'b0, fa} << lza) : {1'b1, fa};
    mb = (eb == '0) ? ({1'b0, fb} << lzb) : {1'b1, fb};
    ea_n = (ea == '0) ? 10'sd1 - signed'({5'd0, lza})
                      : signed'({2'd0, ea});
    eb_n = (eb == '0) ? 10'sd1 - signed'({5'd0, lzb})
                      : signed'({2'd0, eb});
    ze_n = ea_n - eb_n + 10'sd127;
    lt = ma < mb;
    rem_init = lt ? {1'b0, ma, 1'b0} : {2'b0, ma};
    ze_init = lt ? ze_n - 10'sd1 : ze_n;
  end

  logic [26:0] diff;
  logic        ge;

  assign diff = {1'b0, rem_q} - {3'b0, mb_q};
  assign ge = !diff[26];

  logic              tiny_in, lost, g, r, s, inc, ovf;
  logic signed [9:0] sh_raw, e_fin;
  logic [4:0]        sh;
  logic [QBITS-1:0]  qs, qmask;
  logic [24:0]       mant;
  logic [31:0]       z_rnd;

  always_comb begin
    tiny_in = (ze_q <= 10'sd0);
    sh_raw = 10'sd1 - ze_q;
    sh = 5'd0;
    if (tiny_in)
      sh = (sh_raw > 10'(QBITS)) ? 5'(QBITS) : sh_raw[4:0];
    qs = quo_q >> sh;
    qmask = ~({QBITS{1'b1}} << sh);
    lost = |(quo_q & qmask);
    g = qs[1];
    r = qs[0];
    s = lost | (rem_q != '0);
    inc = g & (r | s | qs[2]);
    mant = {1'b0, qs[25:2]} + 25'(inc);
    // a subnormal rounding up to 1.0 lands on exponent 1
    if (tiny_in)
      e_fin = mant[23] ? 10'sd1 : 10'sd0;
    else
      e_fin = ze_q + (mant[24] ? 10'sd1 : 10'sd0);
    ovf = (e_fin >= 10'sd255);
    z_rnd = ovf ? {sign_q, 8'hFF, 23'd0}
                : {sign_q, e_fin[7:0], mant[22:0]};
  end

`ifdef FPU_DIV_FLAGS_EN
  logic [4:0] flags_q, flags_rnd;
  logic       nx, uf;

  always_comb begin
    nx = g | r | s;
    uf = (e_fin == 10'sd0) && nx;
    flags_rnd = {2'b00, ovf, uf & !ovf, nx | ovf};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flags_q <= '0;
    else if (state == UNPACK && spec)
      flags_q <= {is_nv, is_dz, 3'b000};
    else if (state == ROUND)
      flags_q <= flags_rnd;
  end

  assign flags_o = flags_q;
`else
  assign flags_o = 5'b0;
`endif

  assign req_ready_o = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      ze_q <= '0;
      mb_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      z_o <= '0;
      resp_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            a_q <= a_i;
            b_q <= b_i;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= sgn;
          if (spec) begin
            z_o <= spec_z;
            state <= DONE;
          end else begin
            rem_q <= rem_init;
            mb_q <= mb;
            ze_q <= ze_init;
            quo_q <= '0;
            cnt_q <= CW'(QBITS - 1);
            state <= DIV;
          end
        end
        DIV: begin
          rem_q <= (ge ? diff[25:0] : rem_q) << 1;
          quo_q <= {quo_q[QBITS-2:0], ge};
          if (cnt_q == '0)
            state <= ROUND;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        ROUND: begin
          z_o <= z_rnd;
          state <= DONE;
        end
        DONE: begin
          if (!resp_valid_o) begin
            resp_valid_o <= 1'b1;
          end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
